// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store sequencer for a 1 MiB data memory (IDLE -> ACCESS -> RESP).
// Define LSU_MISALIGN_TRAP_EN to fault accesses whose address is not aligned to their size.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_base,
   input  logic [63:0] req_offset,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [63:0] mem_address,
   output logic [63:0] mem_data,
   output logic        mem_write_enable,
   output logic [2:0]  mem_load_type,
   output logic [1:0]  mem_store_type,
   input  logic [63:0] mem_read_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic        resp_is_load
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_next;
   logic [63:0] ea, ea_next, wdata;
   logic [2:0] lt, lt_next;
   logic [1:0] st;
   logic is_ld, illegal, misalign, fault, accept, acc;

   always_ff @(posedge clk) begin
      state <= rst_n ? state_next : IDLE;
   end

   always_comb begin
      ea_next = req_base + req_offset;
      lt_next = req_funct3 == 3'd0 ? 3'b010 :
                req_funct3 == 3'd1 ? 3'b100 :
                req_funct3 == 3'd2 ? 3'b110 :
                req_funct3 == 3'd3 ? 3'b111 :
                req_funct3 == 3'd4 ? 3'b001 :
                req_funct3 == 3'd5 ? 3'b011 :
                req_funct3 == 3'd6 ? 3'b101 : 3'b000;
      illegal = (req_is_load == req_is_store) ||
                (req_is_load ? req_funct3 == 3'b111 : req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = |(ea_next[2:0] & ((3'd1 << req_funct3[1:0]) - 3'd1));
`else
      misalign = 1'b0;
`endif
      fault = illegal || ea_next[63:20] != 44'd0 || misalign;
      // reset gates every memory-side strobe so an aborted store never lands
      req_ready = rst_n && state == IDLE;
      acc = rst_n && state == ACCESS;
      accept = req_valid && req_ready;
      state_next = state == IDLE   ? (accept ? (fault ? RESP : ACCESS) : IDLE) :
                   state == ACCESS ? RESP : (resp_ready ? IDLE : RESP);
      mem_address = ea;
      mem_data = wdata;
      mem_write_enable = acc && !is_ld;
      mem_load_type = acc && is_ld ? lt : 3'b000;
      mem_store_type = acc && !is_ld ? st : 2'b00;
      resp_valid = state == RESP;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ea <= '0;
         wdata <= '0;
         is_ld <= 1'b0;
         lt <= 3'b000;
         st <= 2'b00;
         resp_data <= '0;
         resp_rd <= '0;
         resp_fault <= 1'b0;
         resp_is_load <= 1'b0;
      end else if (accept) begin
         ea <= ea_next;
         wdata <= req_wdata;
         is_ld <= req_is_load;
         lt <= lt_next;
         st <= req_funct3[1:0];
         resp_data <= '0;
         resp_rd <= req_rd;
         resp_fault <= fault;
         resp_is_load <= req_is_load;
      end else if (state == ACCESS && is_ld) begin
         resp_data <= mem_read_data;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random checks of load_store_unit against a byte-array memory model.
module tb_load_store_unit;
   logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_ready;
   logic req_is_load = 1'b0, req_is_store = 1'b0;
   logic [2:0] req_funct3 = '0;
   logic [63:0] req_base = '0, req_offset = '0, req_wdata = '0;
   logic [4:0] req_rd = '0;
   logic [63:0] mem_address, mem_data, mem_read_data = '0;
   logic mem_write_enable;
   logic [2:0] mem_load_type;
   logic [1:0] mem_store_type;
   logic resp_valid, resp_ready = 1'b0, resp_fault, resp_is_load;
   logic [63:0] resp_data;
   logic [4:0] resp_rd;
   int errors = 0, checks = 0;
   logic [7:0] ram [0:1048575];
   logic [7:0] refm [0:1048575];
   logic [2:0] lt_tab [8] = '{3'b010, 3'b100, 3'b110, 3'b111, 3'b001, 3'b011, 3'b101, 3'b000};

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
      .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_address(mem_address), .mem_data(mem_data), .mem_write_enable(mem_write_enable),
      .mem_load_type(mem_load_type), .mem_store_type(mem_store_type), .mem_read_data(mem_read_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_fault(resp_fault), .resp_is_load(resp_is_load)
   );

   always #5 clk = ~clk;

   // memory controller: extends read data by load type, writes on the clock edge
   function automatic logic [63:0] env_read(input logic [63:0] a, input logic [2:0] t);
      int n;
      bit s;
      logic [63:0] v;
      case (t)
         3'b010: begin n = 1; s = 1; end
         3'b100: begin n = 2; s = 1; end
         3'b110: begin n = 4; s = 1; end
         3'b111: begin n = 8; s = 0; end
         3'b001: begin n = 1; s = 0; end
         3'b011: begin n = 2; s = 0; end
         3'b101: begin n = 4; s = 0; end
         default: return {$urandom, $urandom};
      endcase
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(ram[a[19:0] + 20'(i)]) << (8 * i));
      if (s && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
      return v;
   endfunction

   always @(negedge clk) mem_read_data <= env_read(mem_address, mem_load_type);

   always @(posedge clk)
      if (mem_write_enable)
         for (int i = 0; i < (1 << mem_store_type); i++)
            ram[mem_address[19:0] + 20'(i)] <= mem_data[8 * i +: 8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_load(input logic [63:0] ea, input logic [2:0] f3);
      int n = 1 << f3[1:0];
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[8 * i +: 8] = refm[20'(ea + 64'(i))];
      if (!f3[2] && n < 8) v = 64'($signed(v << (64 - 8 * n)) >>> (64 - 8 * n));
      return v;
   endfunction

   // drive one request at a negedge and follow it to completion
   task automatic run_op(input bit ld, input bit sto, input logic [2:0] f3, input logic [63:0] base,
                         input logic [63:0] off, input logic [63:0] wd, input logic [4:0] rd,
                         input int stall, output logic [63:0] got);
      logic [63:0] ea, exp;
      bit flt;
      int n;
      ea = base + off;
      n = 1 << f3[1:0];
      flt = (ld == sto) || (ld ? f3 == 3'd7 : f3 > 3'd3) || ea >= 64'h100000;
`ifdef LSU_MISALIGN_TRAP_EN
      if (ea % 64'(n) != 0) flt = 1;
`endif
      exp = (flt || !ld) ? 64'd0 : model_load(ea, f3);
      if (!flt && sto)
         for (int i = 0; i < n; i++) refm[20'(ea + 64'(i))] = wd[8 * i +: 8];
      req_valid = 1; req_is_load = ld; req_is_store = sto; req_funct3 = f3;
      req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
      chk("idle_ready", req_ready, 1);
      chk("idle_resp_valid", resp_valid, 0);
      @(posedge clk); @(negedge clk);
      req_is_load = 1'($urandom); req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_base = {$urandom, $urandom}; req_offset = 64'($urandom); req_rd = 5'($urandom);
      if (!flt) begin
         chk("acc_addr", mem_address, ea);
         chk("acc_we", mem_write_enable, sto);
         chk("acc_load_type", mem_load_type, ld ? lt_tab[f3] : 3'b000);
         chk("acc_store_type", mem_store_type, sto ? f3[1:0] : 2'b00);
         if (sto) chk("acc_wdata", mem_data, wd);
         chk("acc_resp_valid", resp_valid, 0);
         chk("acc_ready", req_ready, 0);
         @(posedge clk); @(negedge clk);
      end else begin
         chk("flt_load_type", mem_load_type, 0);
         chk("flt_we", mem_write_enable, 0);
      end
      chk("resp_valid", resp_valid, 1);
      chk("resp_fault", resp_fault, flt);
      chk("resp_data", resp_data, exp);
      chk("resp_rd", resp_rd, rd);
      chk("resp_is_load", resp_is_load, ld);
      chk("resp_ready_low", req_ready, 0);
      chk("resp_we", mem_write_enable, 0);
      chk("resp_load_type", mem_load_type, 0);
      got = resp_data;
      repeat (stall) begin
         @(posedge clk); @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_data", resp_data, exp);
         chk("hold_ready", req_ready, 0);
      end
      resp_ready = 1;
      @(posedge clk); @(negedge clk);
      resp_ready = 0; req_valid = 0;
      chk("back_idle_valid", resp_valid, 0);
      chk("back_idle_ready", req_ready, 1);
   endtask

   initial begin
      logic [63:0] got, base, off, wd;
      bit ld, sto;
      logic [2:0] f3;
      int r;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_we", mem_write_enable, 0);
      chk("rst_load_type", mem_load_type, 0);
      chk("rst_store_type", mem_store_type, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_fault", resp_fault, 0);
      chk("rst_addr", mem_address, 0);
      for (int i = 0; i < 1048576; i++) refm[i] = ram[i];
      rst_n = 1;
      @(posedge clk); @(negedge clk);
      chk("post_rst_ready", req_ready, 1);
      run_op(0, 1, 3'b011, 64'h100, 64'h8, 64'h1122334455667788, 5'd3, 0, got);
      chk("sd_resp_data", got, 64'd0);
      run_op(1, 0, 3'b000, 64'h100, 64'h8, 64'd0, 5'd7, 0, got);
      chk("lb_sign_ext", got, 64'hFFFFFFFFFFFFFF88);
      run_op(1, 0, 3'b100, 64'h100, 64'h8, 64'd0, 5'd8, 0, got);
      chk("lbu_zero_ext", got, 64'h88);
      run_op(1, 0, 3'b010, 64'hFFFFF, 64'h1, 64'd0, 5'd9, 0, got);
      run_op(1, 0, 3'b010, 64'h100, 64'h2, 64'd0, 5'd10, 0, got);
      run_op(1, 0, 3'b011, 64'h100, 64'h8, 64'd0, 5'd11, 5, got);
      chk("stall_ld", got, 64'h1122334455667788);
      run_op(1, 1, 3'b000, 64'h100, 64'h0, 64'd0, 5'd1, 1, got);
      run_op(0, 0, 3'b000, 64'h100, 64'h0, 64'd0, 5'd2, 0, got);
      run_op(1, 0, 3'b111, 64'h100, 64'h0, 64'd0, 5'd3, 0, got);
      run_op(0, 1, 3'b100, 64'h100, 64'h0, 64'd0, 5'd4, 0, got);
      run_op(0, 1, 3'b000, 64'hFFFFF, 64'h0, 64'hAB, 5'd5, 0, got);
      run_op(1, 0, 3'b100, 64'hFFFFF, 64'h0, 64'd0, 5'd6, 0, got);
      // reset during a word store must leave memory untouched
      req_valid = 1; req_is_load = 0; req_is_store = 1; req_funct3 = 3'b010;
      req_base = 64'h200; req_offset = 64'h0; req_wdata = 64'hDEADBEEFCAFEF00D; req_rd = 5'd12;
      @(posedge clk); @(negedge clk);
      req_valid = 0;
      chk("abort_we_before", mem_write_enable, 1);
      rst_n = 0;
      #1 chk("abort_we_gated", mem_write_enable, 0);
      @(posedge clk); @(negedge clk);
      chk("abort_ready", req_ready, 0);
      chk("abort_resp_valid", resp_valid, 0);
      rst_n = 1;
      @(posedge clk); @(negedge clk);
      chk("abort_ready_after", req_ready, 1);
      chk("abort_resp_valid_after", resp_valid, 0);
      for (int i = 0; i < 4; i++) chk("abort_mem", ram[20'h200 + 20'(i)], refm[20'h200 + 20'(i)]);
      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 9);
         ld = r < 5; sto = r >= 5;
         if (r == 0) begin ld = 1'($urandom); sto = ld; end
         f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
         r = $urandom_range(0, 9);
         base = r == 0 ? {$urandom, $urandom} :
                r < 3 ? 64'h000FFF00 + 64'($urandom_range(0, 255)) : 64'($urandom_range(0, 1023));
         off = 64'($urandom_range(0, 64)) - 64'd32;
         wd = {$urandom, $urandom};
         run_op(ld, sto, f3, base, off, wd, 5'($urandom), $urandom_range(0, 2), got);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have ports req_valid input 1, req_ready output 1: request handshake from execute stage.
REQ-004 SHALL have ports req_is_load input 1, req_is_store input 1, req_funct3 input 3: RISC-V op/width encoding.
REQ-005 SHALL have ports req_base input 64, req_offset input 64, req_wdata input 64, req_rd input 5.
REQ-006 SHALL have ports mem_address output 64, mem_data output 64, mem_write_enable output 1, mem_load_type output 3, mem_store_type output 2, mem_read_data input 64: drive the data memory controller.
REQ-007 SHALL have ports resp_valid output 1, resp_ready input 1, resp_data output 64, resp_rd output 5, resp_fault output 1, resp_is_load output 1: writeback handshake.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL accept a request when req_valid&&req_ready; latch effective address EA=req_base+req_offset (64-bit, wrap modulo 2^64), wdata, rd, op, funct3.
REQ-010 SHALL decode loads: funct3 000->load_type 010, 001->100, 010->110, 011->111, 100->001, 101->011, 110->101; 111 illegal.
REQ-011 SHALL decode stores: funct3 000->store_type 00, 001->01, 010->10, 011->11; 1xx illegal.
REQ-012 SHALL treat is_load==is_store (both or neither) as illegal.
REQ-013 SHALL on accept of a legal, non-faulting request go IDLE->ACCESS; on illegal/faulting request go IDLE->RESP with resp_fault=1 and no memory access.
REQ-014 SHALL in ACCESS drive mem_address=EA, mem_data=wdata, load/store type, for exactly one cycle, then go to RESP.
REQ-015 SHALL assert mem_write_enable only during ACCESS of a store; exactly one cycle per store.
REQ-016 SHALL drive mem_load_type=000 and mem_write_enable=0 outside ACCESS and during stores.
REQ-017 SHALL capture mem_read_data into resp_data at the end of ACCESS for loads; resp_data=0 for stores and faults.
REQ-018 SHALL hold resp_valid=1 and all resp_* stable in RESP until resp_ready=1, then go to IDLE next cycle.
REQ-019 SHALL give latency accept->resp_valid of 2 cycles (legal) or 1 cycle (fault); throughput one op per 3 cycles minimum.
REQ-020 SHALL fault when EA[63:20]!=0 (outside 1 MiB data memory).
REQ-021 SHALL ignore req_valid while not in IDLE; no request queuing.

Reset
REQ-022 SHALL on rst_n=0 at a clock edge enter IDLE, clearing resp_valid, resp_fault, resp_is_load, resp_data, resp_rd, latched EA/wdata to 0.
REQ-023 SHALL during reset hold req_ready=0, mem_write_enable=0, mem_load_type=000, mem_store_type=00.
REQ-024 SHALL abort an in-flight op when reset is asserted in ACCESS or RESP; a store in ACCESS at that edge SHALL NOT be written.

Configuration
REQ-025 SHALL with LSU_MISALIGN_TRAP_EN defined fault any access whose EA is not aligned to its size (half: EA[0]!=0, word: EA[1:0]!=0, double: EA[2:0]!=0), skipping ACCESS.
REQ-026 SHALL without LSU_MISALIGN_TRAP_EN issue misaligned accesses unchanged to memory; only REQ-012/REQ-020/illegal funct3 fault.

Verification
REQ-027 SHALL pass: store sd base=0x100, offset=0x8, wdata=0x1122334455667788 -> one cycle mem_write_enable=1, mem_address=0x108, mem_store_type=11; resp_fault=0, resp_data=0.
REQ-028 SHALL pass: lb funct3=000 at 0x108 with memory byte 0x88 -> mem_load_type=010, resp_data=0xFFFFFFFFFFFFFF88 two cycles after accept.
REQ-029 SHALL pass: load base=0xFFFFF, offset=0x1 (EA=0x100000) -> resp_fault=1 one cycle after accept, mem_load_type stays 000.
REQ-030 SHALL pass: with LSU_MISALIGN_TRAP_EN, lw at EA=0x102 -> fault, no ACCESS; without macro -> ACCESS with mem_address=0x102, resp_fault=0.
REQ-031 SHALL pass: resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0, then IDLE one cycle after resp_ready=1.
REQ-032 SHALL pass: rst_n=0 during ACCESS of sw -> memory word unchanged, next cycle req_ready=0, after release req_ready=1, resp_valid=0.
